// File: rtl/uart_tx_frame_ctrl_if.sv
// uart_tx_frame_ctrl_if: request, baud, serializer and line signals of the UART TX framing stage
interface uart_tx_frame_ctrl_if #(parameter int DATA_WIDTH = 8);
  logic                  Data_Valid;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_tick;
  logic                  ser_data;
  logic                  ser_done;
  logic                  ser_en;
  logic                  TX_OUT;
  logic                  busy;
  logic                  frame_err;
  modport master (
    output Data_Valid, P_DATA, PAR_EN, PAR_TYP, TX_tick, ser_data, ser_done,
    input  ser_en, TX_OUT, busy, frame_err
  );
  modport slave (
    input  Data_Valid, P_DATA, PAR_EN, PAR_TYP, TX_tick, ser_data, ser_done,
    output ser_en, TX_OUT, busy, frame_err
  );
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// uart_tx_frame_ctrl: frames serializer bits with start, optional parity and stop bits; watchdog aborts a stuck serializer
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int WDOG_TICKS = DATA_WIDTH + 2
) (
  input logic CLK,
  input logic RST,
  uart_tx_frame_ctrl_if.slave bus
);
  localparam int WW = $clog2(WDOG_TICKS + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t          state;
  logic            par_en_q;
  logic            par_bit;
  logic [WW-1:0]   wdog;
  logic            scnt;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      par_en_q      <= 1'b0;
      par_bit       <= 1'b0;
      wdog          <= '0;
      scnt          <= 1'b0;
      bus.ser_en    <= 1'b0;
      bus.TX_OUT    <= 1'b1;
      bus.busy      <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.frame_err <= 1'b0;
      case (state)
        IDLE: if (bus.Data_Valid) begin
          par_en_q   <= bus.PAR_EN;
          par_bit    <= (^bus.P_DATA) ^ bus.PAR_TYP;
          bus.busy   <= 1'b1;
          bus.TX_OUT <= 1'b0;
          state      <= START;
        end
        START: if (bus.TX_tick) begin
          state      <= DATA;
          bus.ser_en <= 1'b1;
          wdog       <= '0;
        end
        DATA: begin
          bus.TX_OUT <= bus.ser_data;
          if (bus.TX_tick) begin
            wdog <= wdog + 1'b1;
            scnt <= 1'b0;
            if (bus.ser_done) begin
              bus.ser_en <= 1'b0;
              bus.TX_OUT <= par_en_q ? par_bit : 1'b1;
              state      <= par_en_q ? PARITY : STOP;
            end else if (wdog == WW'(WDOG_TICKS - 1)) begin
              // abort skips parity and goes straight to the stop bit(s)
              bus.ser_en    <= 1'b0;
              bus.frame_err <= 1'b1;
              bus.TX_OUT    <= 1'b1;
              state         <= STOP;
            end
          end
        end
        PARITY: if (bus.TX_tick) begin
          bus.TX_OUT <= 1'b1;
          scnt       <= 1'b0;
          state      <= STOP;
        end
        STOP: if (bus.TX_tick) begin
          if (scnt == 1'(STOP_BITS - 1)) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else scnt <= scnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// tb_uart_tx_frame_ctrl: directed frames against a 1-stop and a 2-stop instance sharing one serializer model
module tb_uart_tx_frame_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  logic [3:0] si;
  logic [7:0] ser_byte = 8'h00;
  logic hold_done = 1'b0;
  uart_tx_frame_ctrl_if #(.DATA_WIDTH(8)) bus();
  uart_tx_frame_ctrl_if #(.DATA_WIDTH(8)) bus2();
  uart_tx_frame_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) u_dut (.CLK(CLK), .RST(RST), .bus(bus));
  uart_tx_frame_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2)) u_dut2 (.CLK(CLK), .RST(RST), .bus(bus2));
  always #5 CLK = ~CLK;
  always @(posedge CLK or posedge RST)
    if (RST) si <= 4'd0;
    else if (!bus.ser_en) si <= 4'd0;
    else if (bus.TX_tick) si <= si + 4'd1;
  always @(posedge CLK) if (bus.frame_err) fe_cnt <= fe_cnt + 1;
  assign bus.ser_data    = (si < 4'd8) ? ser_byte[si[2:0]] : 1'b0;
  assign bus.ser_done    = !hold_done && (si == 4'd7);
  assign bus2.Data_Valid = bus.Data_Valid;
  assign bus2.P_DATA     = bus.P_DATA;
  assign bus2.PAR_EN     = bus.PAR_EN;
  assign bus2.PAR_TYP    = bus.PAR_TYP;
  assign bus2.TX_tick    = bus.TX_tick;
  assign bus2.ser_data   = bus.ser_data;
  assign bus2.ser_done   = bus.ser_done;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK) bus.TX_tick = 1'b1;
    @(negedge CLK) bus.TX_tick = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic request(input logic [7:0] d, input logic pe, input logic pt, input logic with_tick);
    @(negedge CLK);
    bus.Data_Valid = 1'b1;
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.TX_tick    = with_tick;
    ser_byte       = d;
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
    bus.TX_tick    = 1'b0;
  endtask

  task automatic frame(input string tag, input logic [7:0] d, input logic pe, input logic pt,
                       input logic exp_par, input int inject, input logic with_tick);
    request(d, pe, pt, with_tick);
    chk({tag, " start"}, bus.TX_OUT, 1'b0);
    chk({tag, " busy"}, bus.busy, 1'b1);
    if (with_tick) begin
      @(negedge CLK);
      chk({tag, " start held"}, bus.TX_OUT, 1'b0);
      chk({tag, " no ser_en in start"}, bus.ser_en, 1'b0);
    end
    tick();
    chk({tag, " ser_en"}, bus.ser_en, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s bit%0d", tag, i), bus.TX_OUT, d[i]);
      if (i == inject) begin
        @(negedge CLK);
        bus.Data_Valid = 1'b1;
        bus.P_DATA     = 8'h3C;
        @(negedge CLK);
        bus.Data_Valid = 1'b0;
      end
      tick();
    end
    chk({tag, " ser_en off"}, bus.ser_en, 1'b0);
    if (pe) begin
      chk({tag, " parity"}, bus.TX_OUT, exp_par);
      tick();
    end
    chk({tag, " stop"}, bus.TX_OUT, 1'b1);
    chk({tag, " busy in stop"}, bus.busy, 1'b1);
    tick();
    chk({tag, " busy drop"}, bus.busy, 1'b0);
    chk({tag, " 2stop second"}, bus2.TX_OUT, 1'b1);
    chk({tag, " 2stop busy"}, bus2.busy, 1'b1);
    tick();
    chk({tag, " 2stop busy drop"}, bus2.busy, 1'b0);
  endtask

  initial begin
    bus.Data_Valid = 1'b0;
    bus.P_DATA     = 8'h00;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.TX_tick    = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst TX_OUT", bus.TX_OUT, 1'b1);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst ser_en", bus.ser_en, 1'b0);
    chk("rst frame_err", bus.frame_err, 1'b0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    frame("t1 A5", 8'hA5, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    frame("t2 A5 even", 8'hA5, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    frame("t2 A5 odd", 8'hA5, 1'b1, 1'b1, 1'b1, -1, 1'b1);
    frame("t4 FF", 8'hFF, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    repeat (10) @(negedge CLK);
    chk("t4 no queued busy", bus.busy, 1'b0);
    chk("t4 no queued line", bus.TX_OUT, 1'b1);
    chk_int("t4 no frame_err", fe_cnt, 0);
    hold_done = 1'b1;
    request(8'hA5, 1'b1, 1'b0, 1'b0);
    tick();
    for (int k = 1; k < 10; k++) tick();
    chk_int("t5 no early abort", fe_cnt, 0);
    chk("t5 ser_en before abort", bus.ser_en, 1'b1);
    tick();
    chk_int("t5 frame_err once", fe_cnt, 1);
    chk("t5 ser_en off", bus.ser_en, 1'b0);
    chk("t5 stop line", bus.TX_OUT, 1'b1);
    chk("t5 busy in stop", bus.busy, 1'b1);
    tick();
    chk("t5 idle", bus.busy, 1'b0);
    chk_int("t5 single pulse", fe_cnt, 1);
    tick();
    hold_done = 1'b0;
    request(8'hA5, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) tick();
    chk("t6 in parity", bus.TX_OUT, 1'b0);
    @(negedge CLK) RST = 1'b1;
    #1;
    chk("t6 rst TX_OUT", bus.TX_OUT, 1'b1);
    chk("t6 rst busy", bus.busy, 1'b0);
    chk("t6 rst ser_en", bus.ser_en, 1'b0);
    chk("t6 rst busy2", bus2.busy, 1'b0);
    @(negedge CLK) RST = 1'b0;
    frame("t3 01 odd", 8'h01, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
